// File: rtl/mem_latch.sv
// mem_latch: MEM/WB pipeline register.
// Captures the write-back control, memory read word, ALU result and
// destination register index once per clk rising edge. stall holds the
// current contents, flush loads an all-zero bubble and overrides stall,
// and the asynchronous active-low rst_n clears everything at once.
//
// Optional feature (macro MEM_LATCH_WB_FWD_EN): adds wb_fwd_data / wb_fwd_we,
// the write-back value and write enable decoded from the latched bundle so
// that earlier stages can forward from it without redoing the mux.
module mem_latch #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int WB_W   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic [WB_W-1:0]   control_wb_in,
   input  logic [DATA_W-1:0] Read_data_in,
   input  logic [DATA_W-1:0] ALU_result_in,
   input  logic [REG_W-1:0]  Write_reg_in,
   output logic [WB_W-1:0]   mem_control_wb,
   output logic [DATA_W-1:0] Read_data,
   output logic [DATA_W-1:0] mem_ALU_result,
   output logic [REG_W-1:0]  mem_Write_reg
`ifdef MEM_LATCH_WB_FWD_EN
   ,
   output logic [DATA_W-1:0] wb_fwd_data,
   output logic              wb_fwd_we
`endif
);

   // Pipeline register: reset clears, flush inserts a bubble, stall holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_control_wb <= '0;
         Read_data      <= '0;
         mem_ALU_result <= '0;
         mem_Write_reg  <= '0;
      end else if (flush) begin
         mem_control_wb <= '0;
         Read_data      <= '0;
         mem_ALU_result <= '0;
         mem_Write_reg  <= '0;
      end else if (!stall) begin
         mem_control_wb <= control_wb_in;
         Read_data      <= Read_data_in;
         mem_ALU_result <= ALU_result_in;
         mem_Write_reg  <= Write_reg_in;
      end
   end

`ifdef MEM_LATCH_WB_FWD_EN
   // Forwarding view of the write-back: bit 0 selects memory data, bit 1
   // enables the write; register 0 is hardwired zero so it never forwards.
   always_comb begin
      wb_fwd_data = mem_ALU_result;
      wb_fwd_we   = 1'b0;
      if (mem_control_wb[0]) begin
         wb_fwd_data = Read_data;
      end
      if (mem_control_wb[1] && (mem_Write_reg != '0)) begin
         wb_fwd_we = 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_latch.sv
// Self-checking bench for mem_latch: directed scenarios (reset, capture,
// stall, flush priority, mid-stream reset, forwarding when enabled)
// followed by randomized traffic compared against a reference model.
module tb_mem_latch;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int WB_W   = 2;

   logic              clk;
   logic              rst_n;
   logic              stall;
   logic              flush;
   logic [WB_W-1:0]   control_wb_in;
   logic [DATA_W-1:0] Read_data_in;
   logic [DATA_W-1:0] ALU_result_in;
   logic [REG_W-1:0]  Write_reg_in;
   logic [WB_W-1:0]   mem_control_wb;
   logic [DATA_W-1:0] Read_data;
   logic [DATA_W-1:0] mem_ALU_result;
   logic [REG_W-1:0]  mem_Write_reg;
`ifdef MEM_LATCH_WB_FWD_EN
   logic [DATA_W-1:0] wb_fwd_data;
   logic              wb_fwd_we;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the contents the latch should be holding right now.
   logic [WB_W-1:0]   m_wb;
   logic [DATA_W-1:0] m_rd;
   logic [DATA_W-1:0] m_alu;
   logic [REG_W-1:0]  m_reg;

   mem_latch #(
      .DATA_W(DATA_W),
      .REG_W (REG_W),
      .WB_W  (WB_W)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .flush         (flush),
      .control_wb_in (control_wb_in),
      .Read_data_in  (Read_data_in),
      .ALU_result_in (ALU_result_in),
      .Write_reg_in  (Write_reg_in),
      .mem_control_wb(mem_control_wb),
      .Read_data     (Read_data),
      .mem_ALU_result(mem_ALU_result),
      .mem_Write_reg (mem_Write_reg)
`ifdef MEM_LATCH_WB_FWD_EN
      ,
      .wb_fwd_data   (wb_fwd_data),
      .wb_fwd_we     (wb_fwd_we)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_inputs(input logic [WB_W-1:0] wb, input logic [DATA_W-1:0] rd,
                             input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] wr);
      control_wb_in = wb;
      Read_data_in  = rd;
      ALU_result_in = alu;
      Write_reg_in  = wr;
   endtask

   task automatic set_model(input logic [WB_W-1:0] wb, input logic [DATA_W-1:0] rd,
                            input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] wr);
      m_wb  = wb;
      m_rd  = rd;
      m_alu = alu;
      m_reg = wr;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".wb"},  32'(mem_control_wb), 32'(m_wb));
      check({tag, ".rd"},  Read_data,           m_rd);
      check({tag, ".alu"}, mem_ALU_result,      m_alu);
      check({tag, ".reg"}, 32'(mem_Write_reg),  32'(m_reg));
`ifdef MEM_LATCH_WB_FWD_EN
      check({tag, ".fwd_data"}, wb_fwd_data, m_wb[0] ? m_rd : m_alu);
      check({tag, ".fwd_we"}, 32'(wb_fwd_we), 32'(m_wb[1] && (m_reg != 0)));
`endif
   endtask

   // One rising edge with reset released: the model follows the behavioural
   // rules (flush zeroes, else stall holds, else take the inputs).
   task automatic edge_and_check(input string tag);
      logic [WB_W-1:0]   n_wb;
      logic [DATA_W-1:0] n_rd;
      logic [DATA_W-1:0] n_alu;
      logic [REG_W-1:0]  n_reg;
      n_wb = m_wb; n_rd = m_rd; n_alu = m_alu; n_reg = m_reg;
      if (flush) begin
         n_wb = '0; n_rd = '0; n_alu = '0; n_reg = '0;
      end else if (!stall) begin
         n_wb = control_wb_in; n_rd = Read_data_in; n_alu = ALU_result_in; n_reg = Write_reg_in;
      end
      @(posedge clk);
      set_model(n_wb, n_rd, n_alu, n_reg);
      #1;
      check_all(tag);
   endtask

   initial begin
      // Reset with no clock edge yet: outputs zero immediately.
      rst_n = 1'b0;
      stall = 1'b0;
      flush = 1'b0;
      set_inputs(2'd1, 32'd2, 32'd3, 5'd4);
      set_model('0, '0, '0, '0);
      #2;
      check_all("reset_no_edge");

      // Held in reset across an edge, still zero.
      @(posedge clk); #1;
      check_all("reset_held");

      // Release between edges; nothing captured until the next edge.
      #2;
      rst_n = 1'b1;
      #1;
      check_all("pre_capture");
      edge_and_check("capture");

      // Inputs changing mid-cycle do not reach outputs.
      #2;
      set_inputs(2'd3, 32'hAAAA_5555, 32'h1234_5678, 5'd31);
      #1;
      check_all("mid_cycle_hold");

      // Stall: two edges hold 1/2/3/4, then release.
      stall = 1'b1;
      set_inputs(2'd2, 32'hDEAD_BEEF, 32'h10, 5'd7);
      edge_and_check("stall_1");
      edge_and_check("stall_2");
      check("stall_hold_rd", Read_data, 32'd2);
      stall = 1'b0;
      edge_and_check("stall_release");
      check("release_rd", Read_data, 32'hDEAD_BEEF);

      // Flush beats stall.
      stall = 1'b1;
      flush = 1'b1;
      edge_and_check("flush_prio");
      check("flush_alu", mem_ALU_result, 32'd0);
      stall = 1'b0;
      flush = 1'b0;

      // Reload 1/2/3/4, then async reset mid-cycle with stall and flush set.
      set_inputs(2'd1, 32'd2, 32'd3, 5'd4);
      edge_and_check("reload");
      #2;
      stall = 1'b1;
      flush = 1'b1;
      rst_n = 1'b0;
      set_model('0, '0, '0, '0);
      #1;
      check_all("async_reset");
      @(posedge clk); #1;
      check_all("async_reset_held");
      #2;
      rst_n = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      set_inputs(2'd3, 32'd5, 32'd6, 5'd9);
      #1;
      check_all("post_reset_wait");
      edge_and_check("post_reset_capture");
      check("post_reset_reg", 32'(mem_Write_reg), 32'd9);

`ifdef MEM_LATCH_WB_FWD_EN
      check("fwd_mem_data", wb_fwd_data, 32'd5);
      check("fwd_we_on", 32'(wb_fwd_we), 32'd1);
      set_inputs(2'd2, 32'd5, 32'd6, 5'd0);
      edge_and_check("fwd_reg0");
      check("fwd_alu_data", wb_fwd_data, 32'd6);
      check("fwd_we_off", 32'(wb_fwd_we), 32'd0);
`endif

      // Randomized traffic: full-width data, random stall/flush mix.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         stall = ($urandom_range(0, 3) == 0);
         flush = ($urandom_range(0, 9) == 0);
         set_inputs(2'($urandom_range(0, 3)), $urandom, $urandom,
                    5'($urandom_range(0, 31)));
         edge_and_check("random");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_latch.md
MEM_LATCH -- requirements
Module: mem_latch

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the width of the read-data and ALU-result paths.
REQ-002 Parameter REG_W, default 5, SHALL set the width of the destination-register index.
REQ-003 Parameter WB_W, default 2, SHALL set the width of the write-back control bundle; bit 1 = RegWrite, bit 0 = MemtoReg.
REQ-004 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 Port stall  in  1  SHALL hold all registered outputs when high.
REQ-007 Port flush  in  1  SHALL load a bubble (all-zero) on the next edge when high.
REQ-008 Port control_wb_in  in  WB_W  SHALL be the MEM-stage write-back control.
REQ-009 Port Read_data_in  in  DATA_W  SHALL be the data-memory read word.
REQ-010 Port ALU_result_in  in  DATA_W  SHALL be the ALU result/address passed from MEM.
REQ-011 Port Write_reg_in  in  REG_W  SHALL be the destination register index.
REQ-012 Port mem_control_wb  out  WB_W  SHALL be the registered control_wb_in.
REQ-013 Port Read_data  out  DATA_W  SHALL be the registered Read_data_in.
REQ-014 Port mem_ALU_result  out  DATA_W  SHALL be the registered ALU_result_in.
REQ-015 Port mem_Write_reg  out  REG_W  SHALL be the registered Write_reg_in.

Function
REQ-016 Each output SHALL be driven directly by a flip-flop; no combinational path from any input to the four registered outputs.
REQ-017 With stall=0 and flush=0, each output SHALL equal its corresponding input sampled at the previous rising clk edge (latency exactly 1 cycle).
REQ-018 With stall=1 and flush=0, all registered outputs SHALL retain their values.
REQ-019 With flush=1, all registered outputs SHALL be zero after the next edge regardless of stall (flush has priority over stall).
REQ-020 Input changes between clock edges SHALL NOT affect outputs until the next rising edge.
REQ-021 Values SHALL pass unmodified at full width; no sign extension, truncation or arithmetic.

Reset
REQ-022 While rst_n=0, all registered outputs SHALL be zero immediately, independent of clk.
REQ-023 Reset assertion mid-operation SHALL override stall and flush; the first capture after deassertion SHALL occur on the first rising edge with rst_n=1.

Configuration
REQ-024 Macro MEM_LATCH_WB_FWD_EN, when defined, SHALL add outputs wb_fwd_data (DATA_W) and wb_fwd_we (1).
REQ-025 With the macro, wb_fwd_data SHALL be combinationally Read_data when mem_control_wb[0]=1, else mem_ALU_result.
REQ-026 With the macro, wb_fwd_we SHALL be mem_control_wb[1] AND (mem_Write_reg != 0).
REQ-027 Without the macro, those ports and logic SHALL NOT exist and behaviour of REQ-001..023 is unchanged.

Verification
REQ-028 Reset: rst_n=0 with inputs 1/2/3/4 -> all outputs 0 without any clk edge.
REQ-029 Capture: rst_n=1, control_wb_in=1, Read_data_in=2, ALU_result_in=3, Write_reg_in=4, one edge -> outputs 1, 2, 3, 4; unchanged before that edge.
REQ-030 Stall: after REQ-029, stall=1, inputs 2/0xDEADBEEF/0x10/7, two edges -> outputs stay 1/2/3/4; stall=0 plus one edge -> 2/0xDEADBEEF/0x10/7.
REQ-031 Flush priority: stall=1 and flush=1 with outputs non-zero, one edge -> all outputs 0.
REQ-032 Async reset mid-stream: rst_n pulled low between edges while outputs are 1/2/3/4 -> outputs 0 at once; rst_n=1, inputs 3/5/6/9, one edge -> outputs 3/5/6/9.
REQ-033 Forwarding (macro defined): latched control 3, Read_data 5, ALU 6, reg 9 -> wb_fwd_data=5, wb_fwd_we=1; control 2, reg 0 -> wb_fwd_data=ALU value, wb_fwd_we=0.
